// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path.
//   SEG_OFF / AN_OFF : all-segments-off / all-anodes-off (active low)
//   shadow_t         : one frame's worth of display data latched at frame start
//   hex_to_seg       : hex nibble -> active-low {g,f,e,d,c,b,a} pattern
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned VALUE_W    = 4 * MAX_DIGITS;

    // Display data held stable for a whole frame.
    typedef struct packed {
        logic [VALUE_W-1:0]    value;
        logic [MAX_DIGITS-1:0] en;
        logic [MAX_DIGITS-1:0] dp;
    } shadow_t;

    // Hex digit to active-low segment pattern; lower-case b and d keep them distinct from 8 and 0.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_decoder.sv
// Combinational hex-to-segment decoder; shares hex_to_seg with every other
// display path so all of them decode identically.
//   nibble : hex digit to show
//   seg_c  : active-low {g,f,e,d,c,b,a} pattern (combinational)
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// One digit is lit per refresh slot, each slot opening with a blanking gap so
// the previous digit's pattern never ghosts onto the next anode. Display data
// is latched once per frame so a frame never shows a mix of old and new data.
//   clk, reset_n : clock, asynchronous active-low reset
//   value        : hex word, digit k shows value[4k+3:4k]; digit 0 is rightmost
//   digit_en     : per-digit enable (dark digits still consume their slot)
//   dp_in        : per-digit decimal point enable
//   an           : anode selects, active low
//   seg          : {g,f,e,d,c,b,a}, active low
//   dp           : decimal point, active low
//   frame_done   : one-cycle pulse after the last slot of a frame
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SLOT_HZ      = 8_000,
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned BLANK_CYCLES = 200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned DIV   = CLK_HZ / SLOT_HZ;
    localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS < 2) ? 1 : $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LEN  = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] STATE_BLANK = 1'b0;
    localparam logic [0:0] STATE_DRIVE = 1'b1;

    // Reject parameter sets that cannot produce a sensible scan.
    if (DIV < 2) begin : g_bad_div
        $error("seg7_scan_driver: CLK_HZ/SLOT_HZ must be at least 2");
    end
    if (BLANK_CYCLES >= DIV) begin : g_bad_blank
        $error("seg7_scan_driver: BLANK_CYCLES must be smaller than CLK_HZ/SLOT_HZ");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("seg7_scan_driver: NUM_DIGITS must be in 1..8");
    end

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_d;
    logic [0:0]       state;
    logic [0:0]       state_d;
    shadow_t          shadow;
    shadow_t          shadow_d;
    logic             primed;

    logic             slot_end_c;
    logic             frame_end_c;
    logic [7:0]       sel_c;
    logic [3:0]       nibble_c;
    logic [6:0]       hex_seg_c;
    logic             lit_c;
    logic             dp_on_c;

    logic [7:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    // Slot/frame sequencing, FSM next state and shadow capture.
    always_comb begin
        slot_end_c  = (count == CNT_LAST);
        frame_end_c = slot_end_c && (idx == IDX_LAST);

        count_d = slot_end_c ? '0 : count + CNT_W'(1);

        idx_d = idx;
        if (slot_end_c) begin
            idx_d = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end

        state_d = state;
        if (slot_end_c) begin
            state_d = (BLANK_CYCLES == 0) ? STATE_DRIVE : STATE_BLANK;
        end else if ((BLANK_CYCLES != 0) && (count == BLANK_LAST)) begin
            state_d = STATE_DRIVE;
        end

        // Latch new data at the frame boundary, and once right after reset so
        // the first frame does not show the all-zero reset contents.
        shadow_d = shadow;
        if (frame_end_c || !primed) begin
            shadow_d.value = value;
            shadow_d.en    = digit_en;
            shadow_d.dp    = dp_in;
        end

        // Outputs are registered, so decode the digit the next cycle will show.
        sel_c    = 8'(1) << idx_d;
        nibble_c = 4'(shadow_d.value >> {idx_d, 2'b00});
        lit_c    = |(shadow_d.en & sel_c);
        dp_on_c  = |(shadow_d.dp & sel_c);
    end

    seg7_hex_decoder u_hex (
        .nibble (nibble_c),
        .seg_c  (hex_seg_c)
    );

    // Output decode: everything off unless driving an enabled digit.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if ((state_d == STATE_DRIVE) && lit_c) begin
            an_d  = ~sel_c;
            seg_d = hex_seg_c;
            dp_d  = ~dp_on_c;
        end
    end

    // State register: slot counter, digit index, FSM state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            idx   <= '0;
            state <= STATE_BLANK;
        end else begin
            count <= count_d;
            idx   <= idx_d;
            state <= state_d;
        end
    end

    // Shadow data and registered display outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow     <= '0;
            primed     <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            shadow     <= shadow_d;
            primed     <= 1'b1;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_done <= frame_end_c;
        end
    end

    // At most one anode active, and none during the blanking gap.
    a_an_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $countones(~an) <= 1);
    a_an_blank: assert property (@(posedge clk) disable iff (!reset_n)
        (count < BLANK_LEN) |-> (an == AN_OFF));

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=10, BLANK_CYCLES=2, NUM_DIGITS=4.
// pos counts clock edges since the last reset release; count = pos%10,
// slot = (pos/10)%4, and frame_done is expected exactly when pos%40 == 0.
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset_n;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic [7:0]  dp_in;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned pos   = 0;
    logic        mon_en = 1'b0;

    // Per-slot expectations for the lit part of a slot (index = slot).
    logic [3:0][7:0] ean;
    logic [3:0][6:0] eseg;
    logic [3:0]      edp;

    int unsigned c;
    int unsigned s;
    logic [7:0]  x_an;
    logic [6:0]  x_seg;
    logic        x_dp;
    logic        x_fd;

    seg7_scan_driver #(
        .CLK_HZ       (1000),
        .SLOT_HZ      (100),
        .NUM_DIGITS   (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout pos=%0d", pos);
        $fatal(1, "bench timed out");
    end

    // Per-cycle guard: never two anodes, never an anode in the blanking gap.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            n_cmp++;
            if (($countones(~an) > 1) || ((pos % 10 < 2) && (an !== 8'hFF))) begin
                n_bad++;
                $display("FAIL an_guard pos=%0d an=%h required one-hot-low and FF in blank", pos, an);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pos++;
        mon_en = 1'b1;
    endtask

    task automatic set_a3f5();
        ean  = {8'hF7, 8'hFB, 8'hFD, 8'hFE};
        eseg = {7'h08, 7'h30, 7'h0E, 7'h12};
        edp  = 4'b1111;
    endtask

    task automatic set_1234();
        ean  = {8'hF7, 8'hFB, 8'hFD, 8'hFE};
        eseg = {7'h79, 7'h24, 7'h30, 7'h19};
        edp  = 4'b1111;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        value    = 32'h0000_A3F5;
        digit_en = 8'h0F;
        dp_in    = 8'h00;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (an !== 8'hFF) begin n_bad++; $display("FAIL reset_an got=%h exp=ff", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
        @(negedge clk);
        reset_n = 1'b1;
        pos     = 0;
        set_a3f5();
        // Slot 0 must be lit for edges 2..9 after release, dark on edges 1 and 10.
        while (pos < 10) begin
            tick();
            x_an  = (pos >= 2 && pos <= 9) ? 8'hFE : 8'hFF;
            x_seg = (pos >= 2 && pos <= 9) ? 7'h12 : 7'h7F;
            n_cmp++; if (an !== x_an) begin n_bad++; $display("FAIL release_an pos=%0d got=%h exp=%h", pos, an, x_an); end
            n_cmp++; if (seg !== x_seg) begin n_bad++; $display("FAIL release_seg pos=%0d got=%h exp=%h", pos, seg, x_seg); end
        end
    endtask

    task automatic test_scan();
        set_a3f5();
        while (pos < 80) begin
            tick();
            c = pos % 10; s = (pos / 10) % 4;
            x_an  = (c < 2) ? 8'hFF : ean[s];
            x_seg = (c < 2) ? 7'h7F : eseg[s];
            x_dp  = (c < 2) ? 1'b1 : edp[s];
            x_fd  = (pos % 40 == 0);
            n_cmp++; if (an !== x_an) begin n_bad++; $display("FAIL scan_an pos=%0d got=%h exp=%h", pos, an, x_an); end
            n_cmp++; if (seg !== x_seg) begin n_bad++; $display("FAIL scan_seg pos=%0d got=%h exp=%h", pos, seg, x_seg); end
            n_cmp++; if (dp !== x_dp) begin n_bad++; $display("FAIL scan_dp pos=%0d got=%b exp=%b", pos, dp, x_dp); end
            n_cmp++; if (frame_done !== x_fd) begin n_bad++; $display("FAIL scan_fd pos=%0d got=%b exp=%b", pos, frame_done, x_fd); end
        end
    endtask

    task automatic test_shadow();
        set_a3f5();
        while (pos < 160) begin
            tick();
            if (pos == 95) value = 32'h0000_1234;
            if (pos == 120) set_1234();
            c = pos % 10; s = (pos / 10) % 4;
            x_an  = (c < 2) ? 8'hFF : ean[s];
            x_seg = (c < 2) ? 7'h7F : eseg[s];
            x_dp  = (c < 2) ? 1'b1 : edp[s];
            x_fd  = (pos % 40 == 0);
            n_cmp++; if (an !== x_an) begin n_bad++; $display("FAIL shadow_an pos=%0d got=%h exp=%h", pos, an, x_an); end
            n_cmp++; if (seg !== x_seg) begin n_bad++; $display("FAIL shadow_seg pos=%0d got=%h exp=%h", pos, seg, x_seg); end
            n_cmp++; if (dp !== x_dp) begin n_bad++; $display("FAIL shadow_dp pos=%0d got=%b exp=%b", pos, dp, x_dp); end
            n_cmp++; if (frame_done !== x_fd) begin n_bad++; $display("FAIL shadow_fd pos=%0d got=%b exp=%b", pos, frame_done, x_fd); end
        end
    endtask

    task automatic test_digit_enable();
        digit_en = 8'h05;
        dp_in    = 8'h02;
        set_1234();
        while (pos < 240) begin
            tick();
            if (pos == 200) begin
                ean  = {8'hFF, 8'hFB, 8'hFF, 8'hFE};
                eseg = {7'h79, 7'h24, 7'h30, 7'h19};
                edp  = 4'b1111;
            end
            c = pos % 10; s = (pos / 10) % 4;
            x_an  = (c < 2) ? 8'hFF : ean[s];
            x_seg = (c < 2) ? 7'h7F : eseg[s];
            x_dp  = (c < 2) ? 1'b1 : edp[s];
            x_fd  = (pos % 40 == 0);
            n_cmp++; if (an !== x_an) begin n_bad++; $display("FAIL enable_an pos=%0d got=%h exp=%h", pos, an, x_an); end
            if (c < 2 || x_an != 8'hFF) begin
                n_cmp++; if (seg !== x_seg) begin n_bad++; $display("FAIL enable_seg pos=%0d got=%h exp=%h", pos, seg, x_seg); end
            end
            n_cmp++; if (dp !== x_dp) begin n_bad++; $display("FAIL enable_dp pos=%0d got=%b exp=%b", pos, dp, x_dp); end
            n_cmp++; if (frame_done !== x_fd) begin n_bad++; $display("FAIL enable_fd pos=%0d got=%b exp=%b", pos, frame_done, x_fd); end
        end
    endtask

    task automatic test_decimal_point();
        digit_en = 8'h0F;
        dp_in    = 8'h05;
        while (pos < 320) begin
            tick();
            if (pos == 280) begin
                set_1234();
                edp = 4'b1010;
            end
            c = pos % 10; s = (pos / 10) % 4;
            x_an  = (c < 2) ? 8'hFF : ean[s];
            x_seg = (c < 2) ? 7'h7F : eseg[s];
            x_dp  = (c < 2) ? 1'b1 : edp[s];
            x_fd  = (pos % 40 == 0);
            n_cmp++; if (an !== x_an) begin n_bad++; $display("FAIL dpt_an pos=%0d got=%h exp=%h", pos, an, x_an); end
            if (c < 2 || x_an != 8'hFF) begin
                n_cmp++; if (seg !== x_seg) begin n_bad++; $display("FAIL dpt_seg pos=%0d got=%h exp=%h", pos, seg, x_seg); end
            end
            n_cmp++; if (dp !== x_dp) begin n_bad++; $display("FAIL dpt_dp pos=%0d got=%b exp=%b", pos, dp, x_dp); end
            n_cmp++; if (frame_done !== x_fd) begin n_bad++; $display("FAIL dpt_fd pos=%0d got=%b exp=%b", pos, frame_done, x_fd); end
        end
    endtask

    task automatic test_mid_reset();
        while (pos % 40 != 25) tick();
        // Slot 2, count 5: digit 2 is lit right now.
        n_cmp++; if (an !== 8'hFB) begin n_bad++; $display("FAIL midrst_pre_an got=%h exp=fb", an); end
        reset_n  = 1'b0;
        mon_en   = 1'b0;
        value    = 32'h0000_BEEF;
        digit_en = 8'h0F;
        dp_in    = 8'h00;
        #1;
        n_cmp++; if (an !== 8'hFF) begin n_bad++; $display("FAIL midrst_an got=%h exp=ff", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL midrst_seg got=%h exp=7f", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL midrst_dp got=%b exp=1", dp); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (an !== 8'hFF) begin n_bad++; $display("FAIL midrst_hold_an got=%h exp=ff", an); end
        @(negedge clk);
        reset_n = 1'b1;
        pos     = 0;
        ean  = {8'hF7, 8'hFB, 8'hFD, 8'hFE};
        eseg = {7'h03, 7'h06, 7'h06, 7'h0E};
        edp  = 4'b1111;
        while (pos < 40) begin
            tick();
            c = pos % 10; s = (pos / 10) % 4;
            x_an  = (c < 2) ? 8'hFF : ean[s];
            x_seg = (c < 2) ? 7'h7F : eseg[s];
            x_dp  = (c < 2) ? 1'b1 : edp[s];
            x_fd  = (pos % 40 == 0);
            n_cmp++; if (an !== x_an) begin n_bad++; $display("FAIL restart_an pos=%0d got=%h exp=%h", pos, an, x_an); end
            n_cmp++; if (seg !== x_seg) begin n_bad++; $display("FAIL restart_seg pos=%0d got=%h exp=%h", pos, seg, x_seg); end
            n_cmp++; if (dp !== x_dp) begin n_bad++; $display("FAIL restart_dp pos=%0d got=%b exp=%b", pos, dp, x_dp); end
            n_cmp++; if (frame_done !== x_fd) begin n_bad++; $display("FAIL restart_fd pos=%0d got=%b exp=%b", pos, frame_done, x_fd); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_shadow();
        test_digit_enable();
        test_decimal_point();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
